regfile_wport_arbiter: RTL and testbench
========================================

Name: regfile_wport_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 32x32 three-port register file between NREQ requesters (ALU writeback, load unit, etc.).
- Accepts one write per cycle.
- Stages the winning write into a registered write-port drive (write/wreg/wdata).
- Provides read-after-write bypass flags for the two read ports.
- Sits between the writeback units and the register file.

Parameters:
- NREQ, 4, number of write requesters (2..8).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- hold  input  1  stall; blocks all grants while 1.
- req  input  NREQ  per-requester write request, level.
- req_addr  input  NREQ*AW  packed destination register; requester i uses bits [i*AW +: AW].
- req_data  input  NREQ*DW  packed write data; requester i uses bits [i*DW +: DW].
- gnt  output  NREQ  one-hot acceptance, combinational, same cycle as the request.
- rf_write  output  1  register-file write enable, registered.
- rf_wreg  output  AW  register-file write address, registered.
- rf_wdata  output  DW  register-file write data, registered.
- rd_addr1  input  AW  read port 1 address, as presented to the register file.
- rd_addr2  input  AW  read port 2 address.
- byp1  output  1  the write in flight targets rd_addr1.
- byp2  output  1  the write in flight targets rd_addr2.
- byp_data  output  DW  data to forward; equals rf_wdata.
- busy  output  1  some req is pending but no grant was issued this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - rf_write=0, rf_wreg=0, rf_wdata=0, priority pointer ptr=0.
  - gnt, byp1, byp2 and busy therefore evaluate to 0 while req=0.
- Handshake:
  - Requester i raises req[i] with address and data stable.
  - It holds all three until it sees gnt[i]=1 while req[i]=1 in the same cycle.
  - The transfer completes on that rising edge. The requester may drop req[i] or present a new write in the next cycle.
- Arbitration (combinational, each cycle hold=0):
  - Scan requesters in order ptr, ptr+1, ..., modulo NREQ.
  - The first with req set wins; gnt = one-hot of the winner.
  - With hold=1 or no requests, gnt=0.
- Pointer: on an edge with a grant to i, ptr <= (i+1) mod NREQ. Otherwise ptr holds.
- Staging (latency 1):
  - On an edge with a grant: rf_write<=1, rf_wreg<=req_addr[i], rf_wdata<=req_data[i].
  - Otherwise rf_write<=0; rf_wreg and rf_wdata hold their last values.
  - The register file commits at the following edge, so the write lands 2 edges after the request cycle begins.
- Bypass (combinational):
  - byp1 = rf_write && (rf_wreg == rd_addr1).
  - byp2 = rf_write && (rf_wreg == rd_addr2).
  - This covers the case where the register file samples the old value on the same edge it writes.
- busy = (|req) && !(|gnt).
- Simultaneous events:
  - All requesters active: grants rotate strictly, one per cycle, no requester waits more than NREQ-1 cycles.
  - Hold asserted mid-stream: the staged write already registered still drives rf_write for its one cycle. No new grant is issued.
- Reset mid-operation: the staged write is discarded and rf_write drops immediately. Requests in progress must re-request after reset.
- Same destination from two requesters in consecutive cycles: both are written in grant order; the later one wins.

Optional Feature:
- Macro: ZERO_REG_PROTECT_EN.
- Defined:
  - A granted request with address 0 is still granted (gnt pulses, ptr advances).
  - rf_write stays 0 for that slot, so r0 is never written.
  - byp1 and byp2 are never asserted for address 0.
- Undefined: address 0 is treated like any other register.

Decomposition:
- Package regfile_pkg: AW, DW, register count (32), and the ZERO_REG address constant.
- Sub-module rr_pick: combinational round-robin priority picker (inputs req and ptr; output one-hot gnt).
- Pointer, staging registers and bypass compare stay in the top module.

Test Plan:
- Reset, then req=0001, addr0=3, data0=0xDEADBEEF:
  - gnt=0001 in the same cycle.
  - Next cycle rf_write=1, rf_wreg=3, rf_wdata=0xDEADBEEF.
  - ptr becomes 1.
- req=1111 held, distinct addresses, 8 cycles: gnt sequence 0001,0010,0100,1000,0001,...; rf_write=1 on every cycle after the first.
- Hold during traffic:
  - req=0011, hold=1 for 3 cycles: gnt=0, busy=1, rf_write=0 from the second cycle on.
  - Release hold: gnt=0001 first.
- Bypass:
  - Grant write to r7 while rd_addr1=7, rd_addr2=8 in the next cycle.
  - Required: byp1=1, byp2=0, byp_data equals the written value.
- ZERO_REG_PROTECT_EN defined, write to r0 with data 0x1234:
  - gnt pulses.
  - Next cycle rf_write=0, byp1=0 with rd_addr1=0.
  - Undefined build: rf_write=1.
- Assert rst_n=0 in the cycle after a grant: rf_write drops to 0 without waiting for a clock edge. ptr=0 after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file geometry for the write-port arbiter and its picker.
package regfile_pkg;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = '0;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr wins.
module rr_pick
  import regfile_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  int          idx;
  logic [PW-1:0] sel;
  logic        found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter for the register-file write port with staged write and RAW bypass flags.
// Optional: ZERO_REG_PROTECT_EN suppresses writes and bypass for register 0.
module regfile_wport_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = RF_AW,
  parameter int DW   = RF_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hold,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic               rf_write,
  output logic [AW-1:0]      rf_wreg,
  output logic [DW-1:0]      rf_wdata,
  input  logic [AW-1:0]      rd_addr1,
  input  logic [AW-1:0]      rd_addr2,
  output logic               byp1,
  output logic               byp2,
  output logic [DW-1:0]      byp_data,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] pick;
  logic [PW-1:0]   win_idx_p0;
  logic [AW-1:0]   win_addr_p0;
  logic [DW-1:0]   win_data_p0;
  logic            vld_p0;
  logic            wr_en_p0;
  logic            vld_p1;
  logic [AW-1:0]   wreg_p1;
  logic [DW-1:0]   wdata_p1;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick)
  );

  assign gnt    = hold ? '0 : pick;
  assign vld_p0 = |gnt;
  assign busy   = (|req) && !(|gnt);

  always_comb begin
    win_idx_p0  = '0;
    win_addr_p0 = '0;
    win_data_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx_p0  = PW'(i);
        win_addr_p0 = req_addr[i*AW +: AW];
        win_data_p0 = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    if (win_idx_p0 == PW'(NREQ - 1)) ptr_nxt = '0;
    else                             ptr_nxt = win_idx_p0 + PW'(1);
  end

`ifdef ZERO_REG_PROTECT_EN
  assign wr_en_p0 = vld_p0 && (win_addr_p0 != AW'(RF_ZERO_REG));
`else
  assign wr_en_p0 = vld_p0;
`endif

  // p0 -> p1: stage the winning write onto the register-file port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      vld_p1   <= 1'b0;
      wreg_p1  <= '0;
      wdata_p1 <= '0;
    end else if (vld_p0) begin
      ptr      <= ptr_nxt;
      vld_p1   <= wr_en_p0;
      wreg_p1  <= win_addr_p0;
      wdata_p1 <= win_data_p0;
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  assign rf_write = vld_p1;
  assign rf_wreg  = wreg_p1;
  assign rf_wdata = wdata_p1;
  assign byp_data = wdata_p1;

`ifdef ZERO_REG_PROTECT_EN
  assign byp1 = vld_p1 && (wreg_p1 == rd_addr1) && (wreg_p1 != AW'(RF_ZERO_REG));
  assign byp2 = vld_p1 && (wreg_p1 == rd_addr2) && (wreg_p1 != AW'(RF_ZERO_REG));
`else
  assign byp1 = vld_p1 && (wreg_p1 == rd_addr1);
  assign byp2 = vld_p1 && (wreg_p1 == rd_addr2);
`endif

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Scoreboard bench for regfile_wport_arbiter: a reference round-robin model predicts grants and staged writes.
module tb_regfile_wport_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct packed {
    logic          g;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               hold = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               rf_write;
  logic [AW-1:0]      rf_wreg;
  logic [DW-1:0]      rf_wdata;
  logic [AW-1:0]      rd_addr1 = '0;
  logic [AW-1:0]      rd_addr2 = '0;
  logic               byp1, byp2, busy;
  logic [DW-1:0]      byp_data;

  logic [AW-1:0] addr_m [NREQ];
  logic [DW-1:0] data_m [NREQ];
  exp_t          sbq [$];
  int            mptr = 0;
  bit            refresh = 1'b0;
  int            checks = 0;
  int            errors = 0;

  regfile_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hold     (hold),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .rf_write (rf_write),
    .rf_wreg  (rf_wreg),
    .rf_wdata (rf_wdata),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .byp1     (byp1),
    .byp2     (byp2),
    .byp_data (byp_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = addr_m[i];
      req_data[i*DW +: DW] = data_m[i];
    end
  end

  task automatic cycle(input logic [NREQ-1:0] r, input logic h);
    logic [NREQ-1:0] eg;
    exp_t e;
    int w;
    @(negedge clk);
    req  = r;
    hold = h;
    #1;
    eg = '0;
    w  = -1;
    if (!h) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (mptr + k) % NREQ;
        if (w < 0 && r[idx]) begin
          w = idx;
          eg[idx] = 1'b1;
        end
      end
    end
    checks++;
    if (gnt !== eg) begin
      errors++;
      $display("FAIL gnt: got %b expected %b (req=%b hold=%b)", gnt, eg, r, h);
    end
    checks++;
    if (busy !== ((|r) && (w < 0))) begin
      errors++;
      $display("FAIL busy: got %b expected %b", busy, ((|r) && (w < 0)));
    end
    e = '0;
    if (w >= 0) begin
      e.g    = 1'b1;
      e.addr = addr_m[w];
      e.data = data_m[w];
`ifdef ZERO_REG_PROTECT_EN
      e.wr   = (addr_m[w] != '0);
`else
      e.wr   = 1'b1;
`endif
    end
    sbq.push_back(e);
    @(posedge clk);
    if (w >= 0) mptr = (w + 1) % NREQ;
    #1;
    e = sbq.pop_front();
    checks++;
    if (rf_write !== e.wr) begin
      errors++;
      $display("FAIL rf_write: got %b expected %b", rf_write, e.wr);
    end
    if (e.g) begin
      checks++;
      if (rf_wreg !== e.addr || rf_wdata !== e.data) begin
        errors++;
        $display("FAIL staged: got r%0d=%h expected r%0d=%h", rf_wreg, rf_wdata, e.addr, e.data);
      end
      checks++;
      if (byp_data !== e.data) begin
        errors++;
        $display("FAIL byp_data: got %h expected %h", byp_data, e.data);
      end
    end
    checks++;
    if (byp1 !== (e.wr && e.addr == rd_addr1) || byp2 !== (e.wr && e.addr == rd_addr2)) begin
      errors++;
      $display("FAIL bypass: got %b%b expected %b%b", byp1, byp2,
               (e.wr && e.addr == rd_addr1), (e.wr && e.addr == rd_addr2));
    end
    if (w >= 0 && refresh) data_m[w] = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    hold  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    sbq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    hold  = 1'b0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    @(negedge clk);
    checks++;
    if (rf_write !== 1'b0 || rf_wreg !== '0 || rf_wdata !== '0) begin
      errors++;
      $display("FAIL reset_stage: got %b r%0d %h expected 0 r0 0", rf_write, rf_wreg, rf_wdata);
    end
    checks++;
    if (gnt !== '0 || busy !== 1'b0 || byp1 !== 1'b0 || byp2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: got gnt=%b busy=%b byp=%b%b expected all 0", gnt, busy, byp1, byp2);
    end
    rst_n = 1'b1;
    mptr  = 0;
  endtask

  task automatic test_first_write();
    addr_m[0] = 5'd3;
    data_m[0] = 32'hDEADBEEF;
    cycle(4'b0001, 1'b0);
    checks++;
    if (rf_write !== 1'b1 || rf_wreg !== 5'd3 || rf_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL first_write: got %b r%0d %h expected 1 r3 deadbeef", rf_write, rf_wreg, rf_wdata);
    end
    cycle(4'b0011, 1'b0);
    checks++;
    if (rf_wreg !== addr_m[1]) begin
      errors++;
      $display("FAIL ptr_after_first: got r%0d expected r%0d", rf_wreg, addr_m[1]);
    end
    cycle(4'b0000, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    refresh = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      addr_m[i] = AW'(i + 1);
      data_m[i] = $urandom;
    end
    for (int c = 0; c < 8; c++) cycle(4'b1111, 1'b0);
    refresh = 1'b0;
    cycle(4'b0000, 1'b0);
  endtask

  task automatic test_hold();
    do_reset();
    addr_m[0] = 5'd10; data_m[0] = 32'h0000_00A0;
    addr_m[1] = 5'd11; data_m[1] = 32'h0000_00B1;
    cycle(4'b0100, 1'b0);
    for (int c = 0; c < 3; c++) cycle(4'b0011, 1'b1);
    cycle(4'b0011, 1'b0);
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b0);
  endtask

  task automatic test_bypass();
    addr_m[2] = 5'd7;
    data_m[2] = 32'hCAFEF00D;
    rd_addr1  = 5'd7;
    rd_addr2  = 5'd8;
    cycle(4'b0100, 1'b0);
    checks++;
    if (byp1 !== 1'b1 || byp2 !== 1'b0 || byp_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bypass_r7: got %b%b %h expected 10 cafef00d", byp1, byp2, byp_data);
    end
    cycle(4'b0000, 1'b0);
  endtask

  task automatic test_zero_reg();
    logic exp_wr;
`ifdef ZERO_REG_PROTECT_EN
    exp_wr = 1'b0;
`else
    exp_wr = 1'b1;
`endif
    addr_m[1] = 5'd0;
    data_m[1] = 32'h0000_1234;
    rd_addr1  = 5'd0;
    rd_addr2  = 5'd0;
    cycle(4'b0010, 1'b0);
    checks++;
    if (rf_write !== exp_wr || byp1 !== exp_wr) begin
      errors++;
      $display("FAIL zero_reg: got wr=%b byp1=%b expected %b", rf_write, byp1, exp_wr);
    end
    cycle(4'b0000, 1'b0);
  endtask

  task automatic test_same_dest();
    do_reset();
    addr_m[0] = 5'd9; data_m[0] = 32'h1111_AAAA;
    addr_m[1] = 5'd9; data_m[1] = 32'h2222_BBBB;
    cycle(4'b0011, 1'b0);
    cycle(4'b0010, 1'b0);
    cycle(4'b0000, 1'b0);
    checks++;
    if (rf_wreg !== 5'd9 || rf_wdata !== 32'h2222_BBBB) begin
      errors++;
      $display("FAIL same_dest: got r%0d=%h expected r9=2222bbbb", rf_wreg, rf_wdata);
    end
  endtask

  task automatic test_async_reset();
    addr_m[3] = 5'd5;
    data_m[3] = 32'h5555_0005;
    cycle(4'b1000, 1'b0);
    #1;
    rst_n = 1'b0;
    req   = '0;
    #1;
    checks++;
    if (rf_write !== 1'b0 || rf_wreg !== '0 || rf_wdata !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b r%0d %h expected 0 r0 0", rf_write, rf_wreg, rf_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    sbq.delete();
    cycle(4'b1111, 1'b0);
    cycle(4'b0000, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      addr_m[i] = AW'(20 + i);
      data_m[i] = 32'h1000 + i;
    end
    test_reset();
    test_first_write();
    test_round_robin();
    test_hold();
    test_bypass();
    test_zero_reg();
    test_same_dest();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
